keypad_emu: RTL and testbench
=============================

Name: keypad_emu

Overview:
Emulates a 4x4 matrix keypad, acting as the key side of the row/column scan interface. It watches the column drive from the keypad scanner and returns row levels as if a commanded key were physically pressed. Each press includes contact bounce, a hold time and a release gap. Used in benches and board loopback tests to drive the scanner without a physical keypad.

Parameters:
TICK_DIV, 4, clk cycles per emulation tick (>=1)
BOUNCE_TICKS, 3, ticks of bounce on press and on release (>=1)
HOLD_TICKS, 5, ticks of solid contact (>=1)
GAP_TICKS, 2, ticks of forced open contact after release, before the next press is accepted (>=1)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
key_valid  input  1  press request valid
key_code  input  4  hex key to press, sampled on accept
key_ready  output  1  high only in IDLE
cHigh  input  4  column drive from scanner, active-high, cHigh[c] = column c
rows  output  4  row return to scanner, rows[r] = row r
contact  output  1  registered contact state, for debug
done  output  1  1-cycle pulse on GAP exit

Behaviour:
- Clock and reset: one clock `clk`; `reset` is synchronous and active-high.
- Reset values:
  - State IDLE; contact=0; done=0; key_ready=1 once reset deasserts.
  - Tick counter=0; LFSR=8'hA5; latched code=0.
  - rows=0 on the first edge with reset high.
- Key map, code -> (row, col):
  - row0: 1,2,3,A at col0..3
  - row1: 4,5,6,B
  - row2: 7,8,9,C
  - row3: E,0,F,D
- rows[r] = contact & (r==key_row) & cHigh[key_col]. This path is combinational from cHigh, like a real switch; there is no added latency.
- Multiple cHigh bits high: row asserts if the key's column bit is set.
- Handshake: accept when key_valid & key_ready. On accept:
  - key_code is latched.
  - Tick divider is cleared.
  - State moves to BOUNCE_IN on the next edge.
  - key_valid outside IDLE is ignored, not queued.
- Tick: divider counts 0..TICK_DIV-1; tick=1 on the cycle the count equals TICK_DIV-1, then wraps to 0.
- FSM (a per-state tick count clears on each transition):
  - IDLE: contact=0.
  - BOUNCE_IN: BOUNCE_TICKS ticks, then HELD.
  - HELD: contact=1; HOLD_TICKS ticks, then BOUNCE_OUT.
  - BOUNCE_OUT: BOUNCE_TICKS ticks, then GAP.
  - GAP: contact=0; GAP_TICKS ticks, then IDLE with done=1 for that one cycle.
- Total accept-to-done latency: (2*BOUNCE_TICKS+HOLD_TICKS+GAP_TICKS)*TICK_DIV cycles. Defaults give 52.
- Bounce contact value: see Optional Feature. It updates only on tick edges.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. Advances on every tick in any state, except that reset reloads 8'hA5.
- Reset mid-press: the next edge forces IDLE and contact=0, and no done pulse is issued.
- key_code changes after accept have no effect.

Optional Feature:
KEYEMU_BOUNCE_EN
- Defined: in BOUNCE_IN and BOUNCE_OUT, contact takes LFSR[0] at each tick, giving pseudo-random chatter.
  - BOUNCE_IN is forced to 1 on its final tick.
  - BOUNCE_OUT is forced to 0 on its final tick.
- Undefined: contact is 1 for all of BOUNCE_IN and 0 for all of BOUNCE_OUT, a clean edge.
- State durations, done timing and the handshake are identical in both builds.

Test Plan:
1. Map check: reset, then key_code=4'h5 accepted; in HELD, cHigh=4'b0010 -> rows=4'b0010; cHigh=4'b0001 -> rows=4'b0000.
2. Corner key: key_code=4'h0 and cHigh=4'b0010 in HELD -> rows=4'b1000; key_code=4'hD and cHigh=4'b1000 -> rows=4'b1000.
3. Timing, defaults: accept at cycle 0 -> contact=1 exactly for cycles 12..31 (clean build), done pulse at cycle 52, key_ready returns at cycle 52.
4. Busy rejection: key_valid held high with code 4'h1, then 4'h9 presented during HELD -> 4'h9 ignored; after done, 4'h9 is accepted on the first IDLE cycle.
5. Reset mid-HELD: assert reset for 1 cycle -> rows=0 and contact=0 next edge, no done pulse, key_ready=1 after reset.
6. Bounce build (KEYEMU_BOUNCE_EN, LFSR seed A5): contact toggles at least once in BOUNCE_IN, is 1 by HELD entry and 0 by GAP entry; the sequence repeats identically after a second reset.

Source files
------------

// File: rtl/keypad_emu_if.sv
// Key-request handshake and row/column scan signals of the 4x4 keypad emulator.
interface keypad_emu_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_ready;
    logic [3:0] cHigh;
    logic [3:0] rows;
    logic       contact;
    logic       done;

    modport master (
        output key_valid, key_code, cHigh,
        input  key_ready, rows, contact, done
    );

    modport slave (
        input  key_valid, key_code, cHigh,
        output key_ready, rows, contact, done
    );
endinterface

// File: rtl/keypad_emu.sv
// 4x4 matrix keypad emulator: presses one commanded key with bounce, hold and release gap.
// Optional macro KEYEMU_BOUNCE_EN adds LFSR-driven contact chatter during the bounce phases.
module keypad_emu #(
    parameter int unsigned TICK_DIV     = 4,
    parameter int unsigned BOUNCE_TICKS = 3,
    parameter int unsigned HOLD_TICKS   = 5,
    parameter int unsigned GAP_TICKS    = 2
) (
    input  logic        clk,
    input  logic        reset,
    keypad_emu_if.slave kp
);
    localparam int unsigned DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned TW = 16;

    typedef enum logic [2:0] {IDLE, BOUNCE_IN, HELD, BOUNCE_OUT, GAP} state_t;

    state_t          state_q, state_nx;
    logic [DW-1:0]   div_q, div_nx;
    logic [TW-1:0]   tcnt_q, tcnt_nx;
    logic [TW-1:0]   dur;
    logic [7:0]      lfsr_q, lfsr_nx;
    logic [3:0]      code_q, code_nx;
    logic            contact_q, contact_nx;
    logic            done_q, done_nx;
    logic            tick, accept, last, fb;
    logic [1:0]      krow, kcol;

    assign tick   = (div_q == DW'(TICK_DIV - 1));
    assign accept = kp.key_valid & kp.key_ready;
    assign fb     = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    assign last   = tick & (tcnt_q == dur - TW'(1));

    always_comb begin
        unique case (state_q)
            BOUNCE_IN, BOUNCE_OUT: dur = TW'(BOUNCE_TICKS);
            HELD:                  dur = TW'(HOLD_TICKS);
            GAP:                   dur = TW'(GAP_TICKS);
            default:               dur = TW'(1);
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            div_q     <= '0;
            tcnt_q    <= '0;
            lfsr_q    <= 8'hA5;
            code_q    <= '0;
            contact_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_nx;
            div_q     <= div_nx;
            tcnt_q    <= tcnt_nx;
            lfsr_q    <= lfsr_nx;
            code_q    <= code_nx;
            contact_q <= contact_nx;
            done_q    <= done_nx;
        end
    end

    // Contact is registered and only moves on ticks, so in the clean build it rises on
    // HELD entry and falls on HELD exit; the bounce build chatters between those edges.
    always_comb begin
        state_nx   = state_q;
        div_nx     = tick ? '0 : div_q + 1'b1;
        lfsr_nx    = tick ? {lfsr_q[6:0], fb} : lfsr_q;
        tcnt_nx    = tick ? tcnt_q + 1'b1 : tcnt_q;
        code_nx    = code_q;
        contact_nx = contact_q;
        done_nx    = 1'b0;
        unique case (state_q)
            IDLE: begin
                contact_nx = 1'b0;
                tcnt_nx    = '0;
                if (accept) begin
                    code_nx  = kp.key_code;
                    div_nx   = '0;
                    state_nx = BOUNCE_IN;
                end
            end
            BOUNCE_IN: begin
`ifdef KEYEMU_BOUNCE_EN
                if (tick) contact_nx = lfsr_q[0];
`else
                contact_nx = 1'b0;
`endif
                if (last) begin
                    contact_nx = 1'b1;
                    tcnt_nx    = '0;
                    state_nx   = HELD;
                end
            end
            HELD: begin
                contact_nx = 1'b1;
                if (last) begin
`ifdef KEYEMU_BOUNCE_EN
                    contact_nx = 1'b1;
`else
                    contact_nx = 1'b0;
`endif
                    tcnt_nx  = '0;
                    state_nx = BOUNCE_OUT;
                end
            end
            BOUNCE_OUT: begin
`ifdef KEYEMU_BOUNCE_EN
                if (tick) contact_nx = lfsr_q[0];
`else
                contact_nx = 1'b0;
`endif
                if (last) begin
                    contact_nx = 1'b0;
                    tcnt_nx    = '0;
                    state_nx   = GAP;
                end
            end
            GAP: begin
                contact_nx = 1'b0;
                if (last) begin
                    done_nx  = 1'b1;
                    tcnt_nx  = '0;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        unique case (code_q)
            4'h1:    {krow, kcol} = 4'b00_00;
            4'h2:    {krow, kcol} = 4'b00_01;
            4'h3:    {krow, kcol} = 4'b00_10;
            4'hA:    {krow, kcol} = 4'b00_11;
            4'h4:    {krow, kcol} = 4'b01_00;
            4'h5:    {krow, kcol} = 4'b01_01;
            4'h6:    {krow, kcol} = 4'b01_10;
            4'hB:    {krow, kcol} = 4'b01_11;
            4'h7:    {krow, kcol} = 4'b10_00;
            4'h8:    {krow, kcol} = 4'b10_01;
            4'h9:    {krow, kcol} = 4'b10_10;
            4'hC:    {krow, kcol} = 4'b10_11;
            4'hE:    {krow, kcol} = 4'b11_00;
            4'h0:    {krow, kcol} = 4'b11_01;
            4'hF:    {krow, kcol} = 4'b11_10;
            default: {krow, kcol} = 4'b11_11;
        endcase
    end

    // Row return is combinational from the column drive, like a physical switch.
    assign kp.rows      = (4'b0001 << krow) & {4{contact_q & kp.cHigh[kcol]}};
    assign kp.key_ready = (state_q == IDLE) & ~reset;
    assign kp.contact   = contact_q;
    assign kp.done      = done_q;
endmodule

// File: tb/tb_keypad_emu.sv
// Directed bench for keypad_emu: accept/done latency, key map, busy rejection, mid-press reset.
module tb_keypad_emu;
    localparam int LAT = 52;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    keypad_emu_if kif();

    keypad_emu #(
        .TICK_DIV(4),
        .BOUNCE_TICKS(3),
        .HOLD_TICKS(5),
        .GAP_TICKS(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .kp(kif)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         done_q[$];
    logic [3:0] code_q[$];
    int         t0     = -1000;
    bit         busy   = 1'b0;
    bit         rec_on = 1'b0;
    logic       rec_cur[LAT];
    logic       rec_first[LAT];
    logic [3:0] keymap[16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                               4'h4, 4'h5, 4'h6, 4'hB,
                               4'h7, 4'h8, 4'h9, 4'hC,
                               4'hE, 4'h0, 4'hF, 4'hD};

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: update the reference model, then check contact, ready and done.
    task automatic step();
        bit         acc, rst, skip, exp_done;
        logic [3:0] code_s;
        int         k;
        acc    = kif.key_valid && !busy && !reset;
        rst    = reset;
        code_s = kif.key_code;
        @(posedge clk);
        #1;
        if (rst) begin
            busy   = 1'b0;
            t0     = -1000;
            rec_on = 1'b0;
            done_q.delete();
            code_q.delete();
        end else if (acc) begin
            busy = 1'b1;
            t0   = cyc;
            done_q.push_back(cyc + LAT);
            code_q.push_back(code_s);
        end
        k = cyc - t0;
        if (busy && k >= LAT) busy = 1'b0;
        skip = 1'b0;
`ifdef KEYEMU_BOUNCE_EN
        skip = (k >= 0 && k < 12) || (k >= 32 && k < 44);
`endif
        if (!skip) chk("contact", 8'(kif.contact), 8'(k >= 12 && k <= 31));
        chk("key_ready", 8'(kif.key_ready), 8'(!busy && !reset));
        exp_done = (done_q.size() > 0) && (done_q[0] == cyc);
        chk("done", 8'(kif.done), 8'(exp_done));
        if (exp_done) void'(done_q.pop_front());
        if (rec_on && k >= 0 && k < LAT) rec_cur[k] = kif.contact;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic press(input logic [3:0] code);
        kif.key_code  = code;
        kif.key_valid = 1'b1;
        step();
        kif.key_valid = 1'b0;
    endtask

    // Drive column patterns while HELD and compare rows against the bench's own key table.
    task automatic probe();
        logic [3:0] code;
        int r, c;
        r = 0;
        c = 0;
        if (code_q.size() == 0) begin
            n_fail++;
            $display("FAIL probe: no accepted key pending");
            return;
        end
        code = code_q.pop_front();
        for (int i = 0; i < 16; i++) if (keymap[i] == code) begin r = i / 4; c = i % 4; end
        kif.cHigh = 4'(1 << c);             #1; chk("rows_keycol", 8'(kif.rows), 8'(1 << r));
        kif.cHigh = 4'(1 << ((c + 1) % 4)); #1; chk("rows_othercol", 8'(kif.rows), 8'h00);
        kif.cHigh = ~4'(1 << c);            #1; chk("rows_allbutkey", 8'(kif.rows), 8'h00);
        kif.cHigh = 4'hF;                   #1; chk("rows_allcols", 8'(kif.rows), 8'(1 << r));
        kif.cHigh = 4'h0;                   #1; chk("rows_nocol", 8'(kif.rows), 8'h00);
    endtask

    initial begin
        int ndiff, ntog;
        reset         = 1'b1;
        kif.key_valid = 1'b0;
        kif.key_code  = 4'h0;
        kif.cHigh     = 4'hF;

        step();
        chk("reset_rows", 8'(kif.rows), 8'h00);
        step();
        reset     = 1'b0;
        kif.cHigh = 4'h0;
        step();

        // Key 5, full timeline recorded for the repeat comparison at the end.
        rec_on = 1'b1;
        press(4'h5);
        run(15);
        probe();
        run(40);
        rec_on = 1'b0;
        for (int i = 0; i < LAT; i++) rec_first[i] = rec_cur[i];
`ifdef KEYEMU_BOUNCE_EN
        ntog = 0;
        for (int i = 1; i <= 12; i++) if (rec_first[i] !== rec_first[i-1]) ntog++;
        chk("bounce_toggles", 8'(ntog > 0), 8'h01);
`endif

        // Corner keys.
        press(4'h0);
        run(15);
        probe();
        run(40);
        press(4'hD);
        run(15);
        probe();
        run(40);

        // key_valid held across a press; 9 shown while busy must wait for IDLE.
        kif.key_code  = 4'h1;
        kif.key_valid = 1'b1;
        step();
        run(15);
        kif.key_code = 4'h9;
        probe();
        run(37);
        step();
        kif.key_valid = 1'b0;
        run(15);
        probe();
        run(40);

        // Reset in the middle of HELD.
        press(4'hE);
        run(20);
        kif.cHigh = 4'b0001;
        #1;
        chk("held_rows_E", 8'(kif.rows), 8'b0000_1000);
        reset = 1'b1;
        step();
        chk("midrst_rows", 8'(kif.rows), 8'h00);
        reset = 1'b0;
        step();
        kif.cHigh = 4'h0;
        run(60);

        // Same reset/press timing again must reproduce the recorded contact sequence.
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
        rec_on = 1'b1;
        press(4'h5);
        run(15);
        probe();
        run(40);
        rec_on = 1'b0;
        ndiff = 0;
        for (int i = 0; i < LAT; i++) if (rec_cur[i] !== rec_first[i]) ndiff++;
        chk("repeat_sequence", 8'(ndiff), 8'h00);

        chk("done_pending", 8'(done_q.size()), 8'h00);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
